// File: rtl/leaf_multi_echo_if.sv
// leaf_multi_echo_if: packed BFT leaf bundle for NUM_CH channels.
// din/resend/ap_start flow to the leaf; dout/overflow/done flow back.
interface leaf_multi_echo_if #(
  parameter int NUM_CH = 4,
  parameter int PW     = 49
);
  logic [NUM_CH*PW-1:0] din_leaf_bft2interface;
  logic [NUM_CH*PW-1:0] dout_leaf_interface2bft;
  logic [NUM_CH-1:0]    resend;
  logic [NUM_CH-1:0]    ap_start;
  logic [NUM_CH-1:0]    overflow;
  logic [NUM_CH-1:0]    done;

  modport master (
    output din_leaf_bft2interface,
    output resend,
    output ap_start,
    input  dout_leaf_interface2bft,
    input  overflow,
    input  done
  );

  modport slave (
    input  din_leaf_bft2interface,
    input  resend,
    input  ap_start,
    output dout_leaf_interface2bft,
    output overflow,
    output done
  );
endinterface

// File: rtl/leaf_multi_echo.sv
// leaf_multi_echo: NUM_CH independent BFT test leaves (loopback or generator).
// Ports: clk, reset (sync, high), bft slave bundle (din/resend/ap_start in; dout/overflow/done out).
module leaf_multi_echo #(
  parameter int NUM_CH    = 4,
  parameter int PW        = 49,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 8,
  parameter int MODE      = 0,
  parameter int GEN_COUNT = 16,
  parameter logic [NUM_CH*ADDR_W-1:0] DEST = '0
) (
  input  logic             clk,
  input  logic             reset,
  leaf_multi_echo_if.slave bft
);
  localparam int PLW = PW - 1 - ADDR_W;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = (GEN_COUNT < 1) ? 1 : $clog2(GEN_COUNT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] GC       = CW'(GEN_COUNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } gen_state_e;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PW-1:0]     out_q;
    logic [ADDR_W-1:0] dest_i;
    logic              acc;
    logic              free;

    assign dest_i = DEST[i*ADDR_W +: ADDR_W];
    assign acc    = out_q[PW-1] & ~bft.resend[i];
    // register can take a new packet this edge
    assign free   = ~out_q[PW-1] | acc;
    assign bft.dout_leaf_interface2bft[i*PW +: PW] = out_q;

    if (MODE == 0) begin : g_lb
      logic [PLW-1:0] mem [DEPTH];
      logic [AW:0]    wr_ptr;
      logic [AW:0]    rd_ptr;
      logic [AW:0]    cnt;
      logic [PW-1:0]  din_i;
      logic           full;
      logic           empty;
      logic           pop;
      logic           wr;
      logic           drop;
      logic           ovf_q;
      logic           unused_dst;

      assign din_i = bft.din_leaf_bft2interface[i*PW +: PW];
      // inbound dest is overwritten on the way out
      assign unused_dst = ^din_i[PW-2 -: ADDR_W];

      assign cnt   = wr_ptr - rd_ptr;
      assign full  = (cnt == FULL_CNT);
      assign empty = (cnt == '0);
      assign pop   = free & ~empty & bft.ap_start[i];
      // a pop this edge frees a slot for the incoming write
      assign wr    = din_i[PW-1] & (~full | pop);
      assign drop  = din_i[PW-1] & full & ~pop;

      always_ff @(posedge clk) begin
        if (wr) begin
          mem[wr_ptr[AW-1:0]] <= din_i[PLW-1:0];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          ovf_q  <= 1'b0;
          out_q  <= '0;
        end else begin
          if (wr) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
          end
          if (pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
          end
          if (drop) begin
            ovf_q <= 1'b1;
          end
          if (pop) begin
            out_q <= {1'b1, dest_i, mem[rd_ptr[AW-1:0]]};
          end else if (acc) begin
            out_q <= '0;
          end
        end
      end

      assign bft.overflow[i] = ovf_q;
      assign bft.done[i]     = 1'b0;
    end else begin : g_gen
      gen_state_e    st_q;
      gen_state_e    st_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic [PW-1:0] out_d;
      logic          done_q;
      logic          done_d;
      logic          ap_q;
      logic          rise;
      logic          unused_din;

      assign unused_din = ^bft.din_leaf_bft2interface[i*PW +: PW];
      assign rise = bft.ap_start[i] & ~ap_q;

      always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        out_d  = acc ? '0 : out_q;
        unique case (st_q)
          S_IDLE: begin
            if (rise) begin
              st_d   = S_RUN;
              cnt_d  = '0;
              done_d = 1'b0;
            end
          end
          S_RUN: begin
            if (cnt_q != GC) begin
              if (free && bft.ap_start[i]) begin
                out_d = {1'b1, dest_i, PLW'(cnt_q)};
                cnt_d = cnt_q + CW'(1);
              end
            end else if (free) begin
              // last packet has left the register
              st_d = S_DONE;
            end
          end
          S_DONE: begin
            done_d = 1'b1;
            if (rise) begin
              st_d   = S_RUN;
              cnt_d  = '0;
              done_d = 1'b0;
            end
          end
          default: st_d = S_IDLE;
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          st_q   <= S_IDLE;
          cnt_q  <= '0;
          done_q <= 1'b0;
          out_q  <= '0;
          ap_q   <= 1'b0;
        end else begin
          st_q   <= st_d;
          cnt_q  <= cnt_d;
          done_q <= done_d;
          out_q  <= out_d;
          ap_q   <= bft.ap_start[i];
        end
      end

      assign bft.overflow[i] = 1'b0;
      assign bft.done[i]     = done_q;
    end
  end
endmodule

// File: tb/tb_leaf_multi_echo.sv
// tb_leaf_multi_echo: loopback and generator instances vs a queue model.
// Directed vectors plus literal spot checks.
module tb_leaf_multi_echo;
  localparam int NC    = 4;
  localparam int PW    = 49;
  localparam int AW    = 5;
  localparam int PL    = 43;
  localparam int DEPTH = 8;
  localparam int GEN   = 16;
  localparam logic [NC*AW-1:0] DEST = {5'h1F, 5'h13, 5'h0A, 5'h01};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  leaf_multi_echo_if #(.NUM_CH(NC), .PW(PW)) lbi ();
  leaf_multi_echo_if #(.NUM_CH(NC), .PW(PW)) gni ();

  leaf_multi_echo #(
    .NUM_CH(NC), .PW(PW), .ADDR_W(AW), .DEPTH(DEPTH),
    .MODE(0), .GEN_COUNT(GEN), .DEST(DEST)
  ) u_lb (
    .clk(clk),
    .reset(reset),
    .bft(lbi)
  );

  leaf_multi_echo #(
    .NUM_CH(NC), .PW(PW), .ADDR_W(AW), .DEPTH(DEPTH),
    .MODE(1), .GEN_COUNT(GEN), .DEST(DEST)
  ) u_gen (
    .clk(clk),
    .reset(reset),
    .bft(gni)
  );

  // model state
  logic [PL-1:0] mq [NC][$];
  logic [NC-1:0] m_lv;
  logic [PL-1:0] m_lp [NC];
  logic [NC-1:0] m_ovf;
  logic [NC-1:0] g_run, g_fin, g_done, g_v, g_apq;
  int g_ld [NC];
  int g_acc [NC];

  function automatic logic [AW-1:0] dest_of(int c);
    return DEST[c*AW +: AW];
  endfunction

  function automatic logic [PW-1:0] pk(logic [AW-1:0] d, logic [PL-1:0] p);
    return {1'b1, d, p};
  endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 30)
        $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_update();
    logic [PW-1:0] d;
    logic rise;
    for (int c = 0; c < NC; c++) begin
      if (reset) begin
        mq[c].delete();
        m_lv[c] = 1'b0;
        m_lp[c] = '0;
        m_ovf[c] = 1'b0;
        g_run[c] = 1'b0;
        g_fin[c] = 1'b0;
        g_done[c] = 1'b0;
        g_v[c] = 1'b0;
        g_apq[c] = 1'b0;
        g_ld[c] = 0;
        g_acc[c] = 0;
      end else begin
        // loopback: one slot out, queue behind it, pop before push
        if (m_lv[c] && !lbi.resend[c]) m_lv[c] = 1'b0;
        if (!m_lv[c] && lbi.ap_start[c] && mq[c].size() > 0) begin
          m_lp[c] = mq[c].pop_front();
          m_lv[c] = 1'b1;
        end
        d = lbi.din_leaf_bft2interface[c*PW +: PW];
        if (d[PW-1]) begin
          if (mq[c].size() < DEPTH) mq[c].push_back(d[PL-1:0]);
          else m_ovf[c] = 1'b1;
        end
        // generator: packet on the wire carries the accepted count
        rise = gni.ap_start[c] && !g_apq[c];
        g_apq[c] = gni.ap_start[c];
        if (g_v[c] && !gni.resend[c]) begin
          g_v[c] = 1'b0;
          g_acc[c]++;
        end
        if (g_run[c]) begin
          if (g_acc[c] == GEN) begin
            g_run[c] = 1'b0;
            g_fin[c] = 1'b1;
          end else if (!g_v[c] && gni.ap_start[c] && g_ld[c] < GEN) begin
            g_v[c] = 1'b1;
            g_ld[c]++;
          end
        end else begin
          if (g_fin[c]) g_done[c] = 1'b1;
          if (rise) begin
            g_run[c] = 1'b1;
            g_fin[c] = 1'b0;
            g_done[c] = 1'b0;
            g_ld[c] = 0;
            g_acc[c] = 0;
          end
        end
      end
    end
  endtask

  logic [NC*PW-1:0] el, eg;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NC; c++) begin
        el[c*PW +: PW] = m_lv[c] ? pk(dest_of(c), m_lp[c]) : '0;
        eg[c*PW +: PW] = g_v[c] ? pk(dest_of(c), PL'(g_acc[c])) : '0;
      end
      check("lb_dout", lbi.dout_leaf_interface2bft, el);
      check("lb_ovf", lbi.overflow, m_ovf);
      check("lb_done", lbi.done, '0);
      check("gen_dout", gni.dout_leaf_interface2bft, eg);
      check("gen_done", gni.done, g_done);
      check("gen_ovf", gni.overflow, '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic put(int c, logic [PL-1:0] p);
    logic [NC*PW-1:0] v;
    v = '0;
    v[c*PW +: PW] = {1'b1, 5'h1A, p};
    lbi.din_leaf_bft2interface = v;
  endtask

  task automatic idle_din();
    lbi.din_leaf_bft2interface = '0;
  endtask

  function automatic logic [PW-1:0] lb_ch(int c);
    return lbi.dout_leaf_interface2bft[c*PW +: PW];
  endfunction

  function automatic logic [PW-1:0] gn_ch(int c);
    return gni.dout_leaf_interface2bft[c*PW +: PW];
  endfunction

  logic [NC*PW-1:0] xv;

  initial begin
    lbi.din_leaf_bft2interface = '0;
    lbi.resend = '0;
    lbi.ap_start = '0;
    gni.din_leaf_bft2interface = '0;
    gni.resend = '0;
    gni.ap_start = '0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_lb_dout", lbi.dout_leaf_interface2bft, '0);
    check("rst_lb_ovf", lbi.overflow, '0);
    check("rst_gen_done", gni.done, '0);

    // single packet on ch2
    lbi.ap_start = 4'hF;
    put(2, 43'h1234);
    tick();
    idle_din();
    tick();
    xv = '0;
    xv[2*PW +: PW] = pk(5'h13, 43'h1234);
    check("single_ch2", lbi.dout_leaf_interface2bft, xv);
    tick();

    // resend hold on ch0; resend on empty ch1 is ignored
    put(0, 43'h0AAA);
    tick();
    put(0, 43'h0BBB);
    tick();
    idle_din();
    check("hold_a0", lb_ch(0), pk(5'h01, 43'h0AAA));
    lbi.resend = 4'b0011;
    for (int j = 1; j <= 3; j++) begin
      tick();
      check("hold_a", lb_ch(0), pk(5'h01, 43'h0AAA));
    end
    lbi.resend = '0;
    tick();
    check("hold_b", lb_ch(0), pk(5'h01, 43'h0BBB));
    tick();
    check("hold_empty", lb_ch(0), '0);

    // overflow on ch1
    lbi.ap_start = 4'b1101;
    for (int j = 0; j < 9; j++) begin
      put(1, PL'(100 + j));
      tick();
    end
    idle_din();
    check("ovf_set", lbi.overflow, 4'b0010);
    lbi.ap_start = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      tick();
      check("ovf_order", lb_ch(1), pk(5'h0A, PL'(100 + j)));
    end
    tick();
    check("ovf_drop9", lb_ch(1), '0);

    // full FIFO on ch3, write together with first pop
    lbi.ap_start = 4'b0111;
    for (int j = 0; j < 8; j++) begin
      put(3, PL'(200 + j));
      tick();
    end
    check("full_no_ovf", lbi.overflow, 4'b0010);
    lbi.ap_start = 4'b1111;
    put(3, PL'(208));
    tick();
    idle_din();
    check("fullpop_ovf", lbi.overflow, 4'b0010);
    check("fullpop_0", lb_ch(3), pk(5'h1F, PL'(200)));
    for (int j = 1; j <= 8; j++) begin
      tick();
      check("fullpop_seq", lb_ch(3), pk(5'h1F, PL'(200 + j)));
    end

    // generator on ch3
    gni.ap_start = 4'b1000;
    tick();
    check("gen_start", gn_ch(3), '0);
    for (int j = 0; j < GEN; j++) begin
      tick();
      check("gen_seq", gn_ch(3), pk(5'h1F, PL'(j)));
    end
    tick();
    check("gen_last_acc", gni.done, '0);
    check("gen_empty", gn_ch(3), '0);
    tick();
    check("gen_done", gni.done, 4'b1000);
    gni.ap_start = '0;
    tick();
    gni.ap_start = 4'b1000;
    tick();
    check("gen_restart_done", gni.done, '0);
    tick();
    check("gen_restart_0", gn_ch(3), pk(5'h1F, '0));
    gni.ap_start = '0;
    tick();
    tick();
    check("gen_pause", gn_ch(3), '0);
    gni.ap_start = 4'b1000;
    gni.resend = 4'b0001;
    tick();
    gni.resend = '0;
    for (int j = 0; j < 20; j++) tick();
    check("gen_done2", gni.done, 4'b1000);

    // reset with FIFO half full and register valid
    gni.ap_start = '0;
    lbi.ap_start = 4'b1110;
    for (int j = 0; j < 4; j++) begin
      put(0, PL'(300 + j));
      tick();
    end
    idle_din();
    lbi.ap_start = 4'b1111;
    tick();
    check("pre_rst_reg", lb_ch(0), pk(5'h01, PL'(300)));
    reset = 1'b1;
    tick();
    check("rst_mid_dout", lbi.dout_leaf_interface2bft, '0);
    check("rst_mid_ovf", lbi.overflow, '0);
    check("rst_mid_done", gni.done, '0);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    check("post_rst_quiet", lbi.dout_leaf_interface2bft, '0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
